id_control_path: RTL and testbench
==================================

// Module: id_control_path
// PURPOSE
//  Decode/control slice of the 5-stage ARM pipeline: PC+4 adder for IF, combinational
//  ARM instruction control decoder for ID, and a bubble mux that zeroes all control on
//  stall. Muxed controls are registered into an ID/EX control register for the EX stage.
// PARAMETERS
//  PC_INC  4  constant added to pc_in (bytes)
// PORTS
//  clk           in   1   pipeline clock, rising edge
//  reset         in   1   asynchronous, active-low reset (0 = reset)
//  pc_in         in   32  current program counter
//  instr         in   32  IF/ID instruction word
//  bubble        in   1   1 = force all control outputs to 0 (NOP insertion)
//  pc_plus_4     out  32  pc_in + PC_INC
//  id_reg_write  out  1   decoded register-file write enable (after mux)
//  id_mem_write  out  1   decoded data-memory write enable (after mux)
//  id_mem_to_reg out  1   1 = write back memory data, 0 = ALU result (after mux)
//  id_alu_src    out  1   1 = immediate operand, 0 = register operand (after mux)
//  id_status     out  1   update CPSR flags, S bit (after mux)
//  id_alu_op     out  2   00 ADD, 01 SUB, 10 AND, 11 ORR (after mux)
//  id_pc_src     out  1   1 = branch target selected (after mux)
//  ex_*          out  same  registered copies of all seven id_* outputs
// BEHAVIOUR
//  Adder: pc_plus_4 = pc_in + PC_INC, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
//  Decoder is purely combinational. Fields: op = instr[27:26], I = instr[25],
//   opcode = instr[24:21], S/L = instr[20], U = instr[23].
//   The cond field is ignored; conditional execution is resolved elsewhere.
//  instr == 32'h0 (NOP): all controls 0. Takes priority over field decode.
//  op=00, data processing:
//   - alu_src = I; status = S; mem_write = 0; mem_to_reg = 0; pc_src = 0.
//   - reg_write = 1, except opcode 10xx (TST/TEQ/CMP/CMN), which gives 0.
//   - alu_op: 0100/1011 -> 00; 0010/1010 -> 01; 0000/1000 -> 10; 1100 -> 11; others -> 00.
//  op=01, load/store:
//   - alu_src = ~I; status = 0; pc_src = 0; alu_op = U ? 00 : 01.
//   - L=1: reg_write = 1, mem_to_reg = 1, mem_write = 0.
//   - L=0: mem_write = 1, reg_write = 0, mem_to_reg = 0.
//  op=10 with I=1, branch:
//   - pc_src = 1; reg_write = instr[24] (BL link); alu_src = 1; alu_op = 00.
//   - all other controls 0.
//  op=11, or op=10 with I=0: all controls 0.
//  Mux: bubble = 1 -> every id_* output is 0 regardless of instr.
//   bubble = 0 -> id_* equal the decoder outputs. Same delta, no latency.
//  ID/EX register: on each rising clk, ex_* <= id_*; no enable, 1-cycle latency.
//  Reset: reset = 0 clears all ex_* to 0 immediately, without waiting for a clock.
//   While reset is held low, ex_* stay 0.
//   Combinational outputs (pc_plus_4, id_*) are unaffected by reset.
//  Reset release coincident with a clk edge: ex_* update on the first clock edge after
//   reset is sampled high.
//  Bubble asserted for N cycles gives N consecutive all-zero ex_* cycles, then decode resumes.
// TESTING
//  pc_in = 0x0, then 0x8, then 0xFFFFFFFC -> pc_plus_4 = 0x4, 0xC, 0x0.
//  instr = E2110000 (ANDS imm) -> rw=1 alu_src=1 status=1 alu_op=10 mw=0 mtr=0 pc_src=0;
//   instr = E0805183 (ADD reg) -> rw=1 alu_src=0 alu_op=00 status=0.
//  instr = E7D12000 (LDRB reg) -> rw=1 mtr=1 alu_src=0 alu_op=00;
//   instr = E58A5000 (STR imm) -> mw=1 rw=0 alu_src=1 alu_op=00.
//  instr = 1AFFFFFD (BNE) -> pc_src=1 rw=0; instr = DB000009 (BLLE) -> pc_src=1 rw=1;
//   instr = 00000000 -> all 0.
//  ANDS with bubble=1 -> all id_* = 0, and next clk all ex_* = 0;
//   bubble=0 -> ex_* match decode after 1 clk.
//  Drive reset=0 mid-stream while ex_rw=1 -> ex_* = 0 before the next clk edge; hold 3 clks
//   -> stays 0; release -> valid after first edge.

Source files
------------

// File: rtl/id_control_path.sv
// Decode/control slice of a 5-stage ARM pipeline: IF PC adder, ID control decoder,
// stall bubble mux, and the ID/EX control register feeding the EX stage.
module id_control_path #(
  parameter logic [31:0] PC_INC = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr,
  input  logic        bubble,
  output logic [31:0] pc_plus_4,
  output logic        id_reg_write,
  output logic        id_mem_write,
  output logic        id_mem_to_reg,
  output logic        id_alu_src,
  output logic        id_status,
  output logic [1:0]  id_alu_op,
  output logic        id_pc_src,
  output logic        ex_reg_write,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_alu_src,
  output logic        ex_status,
  output logic [1:0]  ex_alu_op,
  output logic        ex_pc_src
);

  logic [1:0] op;
  logic       imm_bit;
  logic [3:0] opcode;
  logic       s_l_bit;
  logic       u_bit;

  logic       dec_reg_write;
  logic       dec_mem_write;
  logic       dec_mem_to_reg;
  logic       dec_alu_src;
  logic       dec_status;
  logic [1:0] dec_alu_op;
  logic       dec_pc_src;

  assign op      = instr[27:26];
  assign imm_bit = instr[25];
  assign opcode  = instr[24:21];
  assign s_l_bit = instr[20];
  assign u_bit   = instr[23];

  // PC increment, wraps modulo 2^32
  assign pc_plus_4 = pc_in + PC_INC;

  // Instruction control decoder; the all-zero word is a NOP ahead of field decode
  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_status     = 1'b0;
    dec_alu_op     = 2'b00;
    dec_pc_src     = 1'b0;
    if (instr == 32'h0000_0000) begin
      dec_reg_write = 1'b0;
    end else begin
      case (op)
        2'b00: begin
          dec_alu_src   = imm_bit;
          dec_status    = s_l_bit;
          // TST/TEQ/CMP/CMN only set flags
          dec_reg_write = (opcode[3:2] == 2'b10) ? 1'b0 : 1'b1;
          case (opcode)
            4'b0100, 4'b1011: dec_alu_op = 2'b00;
            4'b0010, 4'b1010: dec_alu_op = 2'b01;
            4'b0000, 4'b1000: dec_alu_op = 2'b10;
            4'b1100:          dec_alu_op = 2'b11;
            default:          dec_alu_op = 2'b00;
          endcase
        end
        2'b01: begin
          dec_alu_src = ~imm_bit;
          dec_alu_op  = u_bit ? 2'b00 : 2'b01;
          if (s_l_bit) begin
            dec_reg_write  = 1'b1;
            dec_mem_to_reg = 1'b1;
          end else begin
            dec_mem_write = 1'b1;
          end
        end
        2'b10: begin
          if (imm_bit) begin
            dec_pc_src    = 1'b1;
            dec_reg_write = instr[24];
            dec_alu_src   = 1'b1;
          end else begin
            dec_pc_src = 1'b0;
          end
        end
        default: begin
          dec_pc_src = 1'b0;
        end
      endcase
    end
  end

  // Bubble mux: a stall zeroes every control in the same cycle
  always_comb begin
    id_reg_write  = 1'b0;
    id_mem_write  = 1'b0;
    id_mem_to_reg = 1'b0;
    id_alu_src    = 1'b0;
    id_status     = 1'b0;
    id_alu_op     = 2'b00;
    id_pc_src     = 1'b0;
    if (bubble) begin
      id_reg_write = 1'b0;
    end else begin
      id_reg_write  = dec_reg_write;
      id_mem_write  = dec_mem_write;
      id_mem_to_reg = dec_mem_to_reg;
      id_alu_src    = dec_alu_src;
      id_status     = dec_status;
      id_alu_op     = dec_alu_op;
      id_pc_src     = dec_pc_src;
    end
  end

  // ID/EX control register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_reg_write  <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_status     <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_pc_src     <= 1'b0;
    end else begin
      ex_reg_write  <= id_reg_write;
      ex_mem_write  <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_alu_src    <= id_alu_src;
      ex_status     <= id_status;
      ex_alu_op     <= id_alu_op;
      ex_pc_src     <= id_pc_src;
    end
  end

endmodule

// File: tb/tb_id_control_path.sv
// Self-checking bench for id_control_path: directed ARM encodings, randomized
// instructions/bubbles against a field-level reference model, and async reset.
module tb_id_control_path;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] instr;
  logic        bubble;
  logic [31:0] pc_plus_4;
  logic        id_reg_write, id_mem_write, id_mem_to_reg, id_alu_src, id_status, id_pc_src;
  logic [1:0]  id_alu_op;
  logic        ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_status, ex_pc_src;
  logic [1:0]  ex_alu_op;

  int total = 0;
  int bad   = 0;

  id_control_path dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr(instr), .bubble(bubble),
    .pc_plus_4(pc_plus_4),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_src(id_alu_src), .id_status(id_status), .id_alu_op(id_alu_op), .id_pc_src(id_pc_src),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_status(ex_status), .ex_alu_op(ex_alu_op), .ex_pc_src(ex_pc_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {reg_write, mem_write, mem_to_reg, alu_src, status, alu_op[1:0], pc_src}
  function automatic logic [7:0] id_vec();
    return {id_reg_write, id_mem_write, id_mem_to_reg, id_alu_src, id_status, id_alu_op, id_pc_src};
  endfunction

  function automatic logic [7:0] ex_vec();
    return {ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_status, ex_alu_op, ex_pc_src};
  endfunction

  function automatic logic [7:0] pack(input int rw, input int mw, input int mtr, input int as,
                                      input int st, input int aop, input int pcs);
    logic [7:0] v;
    v = {rw[0], mw[0], mtr[0], as[0], st[0], aop[1:0], pcs[0]};
    return v;
  endfunction

  // Reference model straight from the instruction-class rules
  function automatic logic [7:0] model(input logic [31:0] w, input logic bub);
    int op, ibit, opc, sl, u, aop;
    op   = int'(w[27:26]);
    ibit = int'(w[25]);
    opc  = int'(w[24:21]);
    sl   = int'(w[20]);
    u    = int'(w[23]);
    if (bub || w == 32'h0) return 8'h00;
    if (op == 0) begin
      if (opc == 4 || opc == 11) aop = 0;
      else if (opc == 2 || opc == 10) aop = 1;
      else if (opc == 0 || opc == 8) aop = 2;
      else if (opc == 12) aop = 3;
      else aop = 0;
      return pack((opc >= 8 && opc <= 11) ? 0 : 1, 0, 0, ibit, sl, aop, 0);
    end
    if (op == 1) return pack(sl, 1 - sl, sl, 1 - ibit, 0, u ? 0 : 1, 0);
    if (op == 2 && ibit == 1) return pack(int'(w[24]), 0, 0, 1, 0, 0, 1);
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive after a falling edge, check decode, clock it through, check ex_*
  task automatic step(input logic [31:0] w, input logic bub, input string tag);
    logic [7:0] e;
    @(negedge clk);
    instr  = w;
    bubble = bub;
    #1;
    e = model(w, bub);
    check({tag, "_id"}, {24'h0, id_vec()}, {24'h0, e});
    @(posedge clk);
    #1;
    check({tag, "_ex"}, {24'h0, ex_vec()}, {24'h0, e});
  endtask

  logic [31:0] pcs [3];
  logic [31:0] pce [3];
  logic [31:0] w;

  initial begin
    reset  = 1'b0;
    pc_in  = 32'h0;
    instr  = 32'hE211_0000;
    bubble = 1'b0;
    #2;
    check("rst_ex", {24'h0, ex_vec()}, 32'h0);
    check("rst_id_live", {24'h0, id_vec()}, {24'h0, pack(1, 0, 0, 1, 1, 2, 0)});
    check("rst_pc_live", pc_plus_4, 32'h4);
    @(negedge clk);
    reset = 1'b1;

    pcs[0] = 32'h0; pcs[1] = 32'h8; pcs[2] = 32'hFFFF_FFFC;
    pce[0] = 32'h4; pce[1] = 32'hC; pce[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      pc_in = pcs[i];
      #1;
      check("pc_plus_4", pc_plus_4, pce[i]);
    end

    // Directed encodings, with absolute expectations
    step(32'hE211_0000, 1'b0, "ands");
    check("ands_abs", {24'h0, ex_vec()}, {24'h0, pack(1, 0, 0, 1, 1, 2, 0)});
    step(32'hE080_5183, 1'b0, "add");
    check("add_abs", {24'h0, ex_vec()}, {24'h0, pack(1, 0, 0, 0, 0, 0, 0)});
    step(32'hE7D1_2000, 1'b0, "ldrb");
    check("ldrb_abs", {24'h0, ex_vec()}, {24'h0, pack(1, 0, 1, 0, 0, 0, 0)});
    step(32'hE58A_5000, 1'b0, "str");
    check("str_abs", {24'h0, ex_vec()}, {24'h0, pack(0, 1, 0, 1, 0, 0, 0)});
    step(32'h1AFF_FFFD, 1'b0, "bne");
    check("bne_abs", {24'h0, ex_vec()}, {24'h0, pack(0, 0, 0, 1, 0, 0, 1)});
    step(32'hDB00_0009, 1'b0, "blle");
    check("blle_abs", {24'h0, ex_vec()}, {24'h0, pack(1, 0, 0, 1, 0, 0, 1)});
    step(32'h0000_0000, 1'b0, "nop");
    step(32'hE155_0006, 1'b0, "cmp");
    check("cmp_abs", {24'h0, ex_vec()}, {24'h0, pack(0, 0, 0, 0, 1, 1, 0)});

    // Bubble run of 3 cycles, then decode resumes
    for (int i = 0; i < 3; i++) begin
      step(32'hE211_0000, 1'b1, "bubble");
      check("bubble_abs", {24'h0, ex_vec()}, 32'h0);
    end
    step(32'hE211_0000, 1'b0, "resume");
    check("resume_abs", {24'h0, ex_vec()}, {24'h0, pack(1, 0, 0, 1, 1, 2, 0)});

    // Async reset mid-stream while ex_reg_write is high
    @(negedge clk);
    check("pre_rst_rw", {31'h0, ex_reg_write}, 32'h1);
    reset = 1'b0;
    #1;
    check("async_clear", {24'h0, ex_vec()}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", {24'h0, ex_vec()}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    instr = 32'hE080_5183;
    #1;
    check("rel_before_edge", {24'h0, ex_vec()}, 32'h0);
    @(posedge clk);
    #1;
    check("rel_after_edge", {24'h0, ex_vec()}, {24'h0, model(32'hE080_5183, 1'b0)});

    // Randomized stream
    for (int i = 0; i < 300; i++) begin
      w = $urandom();
      if ($urandom_range(0, 15) == 0) w = 32'h0;
      pc_in = $urandom();
      step(w, ($urandom_range(0, 3) == 0), "rand");
      check("rand_pc", pc_plus_4, pc_in + 32'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
